// File: rtl/serial_subtractor_4bit_if.sv
// Handshake bundle for the bit-serial subtractor.
// Valid/ready rule, both directions: a transfer happens on a rising clock edge
// where valid and ready are both high; the sender holds its payload stable
// while valid is high and ready is low, and ready never depends
// combinationally on valid.
interface serial_subtractor_4bit_if #(
   parameter int WIDTH = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] d;
   logic             bout;

   // Upstream/downstream side: supplies operands, consumes the result.
   modport master (
      output in_valid, a, b, bin, out_ready,
      input  in_ready, out_valid, d, bout
   );

   // Subtractor side.
   modport slave (
      input  in_valid, a, b, bin, out_ready,
      output in_ready, out_valid, d, bout
   );
endinterface

// File: rtl/serial_subtractor_4bit.sv
// Bit-serial subtractor: {bout,d} = a - b - bin, one bit per clock, LSB first.
// IDLE accepts operands, RUN processes WIDTH bits, DONE holds the result
// until downstream takes it. The result registers are only written at the
// final bit edge, so d/bout stay at the last result through IDLE and RUN.
// All outputs come straight from registers.
module serial_subtractor_4bit #(
   parameter int WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   serial_subtractor_4bit_if.slave bus_if,
   output logic [1:0]              dbg_state_o
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q,  state_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic [WIDTH-1:0] a_sh_q,   a_sh_d;
   logic [WIDTH-1:0] b_sh_q,   b_sh_d;
   logic [WIDTH-1:0] d_sh_q,   d_sh_d;
   logic             brw_q,    brw_d;
   logic [WIDTH-1:0] d_res_q,  d_res_d;
   logic             bout_q,   bout_d;

   logic             a_bit;
   logic             b_bit;
   logic             diff_bit;
   logic             brw_next;
   logic [WIDTH:0]   d_cat;
   logic [WIDTH-1:0] d_shifted;

   // One full-subtractor cell on the current LSBs, plus the d shift-in at the MSB.
   always_comb begin
      a_bit     = a_sh_q[0];
      b_bit     = b_sh_q[0];
      diff_bit  = a_bit ^ b_bit ^ brw_q;
      brw_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & brw_q);
      d_cat     = {diff_bit, d_sh_q};
      d_shifted = d_cat[WIDTH:1];
   end

   // Next-state logic for the IDLE/RUN/DONE controller and its datapath.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      d_sh_d  = d_sh_q;
      brw_d   = brw_q;
      d_res_d = d_res_q;
      bout_d  = bout_q;
      case (state_q)
         S_IDLE: begin
            // in_ready is high throughout IDLE, so in_valid alone is the handshake.
            if (bus_if.in_valid) begin
               a_sh_d  = bus_if.a;
               b_sh_d  = bus_if.b;
               brw_d   = bus_if.bin;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            d_sh_d = d_shifted;
            brw_d  = brw_next;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               d_res_d = d_shifted;
               bout_d  = brw_next;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (bus_if.out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         d_sh_q  <= '0;
         brw_q   <= 1'b0;
         d_res_q <= '0;
         bout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         d_sh_q  <= d_sh_d;
         brw_q   <= brw_d;
         d_res_q <= d_res_d;
         bout_q  <= bout_d;
      end
   end

   // Handshake flags decode directly from the state register.
   always_comb begin
      bus_if.in_ready  = (state_q == S_IDLE);
      bus_if.out_valid = (state_q == S_DONE);
      bus_if.d         = d_res_q;
      bus_if.bout      = bout_q;
      dbg_state_o      = state_q;
   end

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// Directed bench for serial_subtractor_4bit: reset, basic and borrow cases,
// backpressure, reset mid-operation, and an exhaustive sweep with random stalls.
module tb_serial_subtractor_4bit;

   localparam int WIDTH = 4;

   logic       clk;
   logic       rst_n;
   logic [1:0] dbg_state;

   int checks   = 0;
   int failures = 0;

   logic [4:0] exp_q[$];
   logic [3:0] last_a;
   logic [3:0] last_b;
   logic       last_bin;

   serial_subtractor_4bit_if #(.WIDTH(WIDTH)) bus ();

   serial_subtractor_4bit #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus_if      (bus),
      .dbg_state_o (dbg_state)
   );

   // Clock and watchdog.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for in_ready, presents operands for one accept edge.
   task automatic start_op(input logic [3:0] a_v, input logic [3:0] b_v, input logic bin_v);
      int cyc;
      cyc = 0;
      while (bus.in_ready !== 1'b1 && cyc < 50) begin
         tick();
         cyc++;
      end
      check("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
      bus.a        = a_v;
      bus.b        = b_v;
      bus.bin      = bin_v;
      bus.in_valid = 1'b1;
      last_a       = a_v;
      last_b       = b_v;
      last_bin     = bin_v;
      tick();
      bus.in_valid = 1'b0;
      bus.a        = 4'($urandom_range(0, 15));
      bus.b        = 4'($urandom_range(0, 15));
      bus.bin      = 1'($urandom_range(0, 1));
      check("in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
   endtask

   // Counts cycles from the accept edge to out_valid.
   task automatic wait_valid();
      int cyc;
      cyc = 0;
      while (bus.out_valid !== 1'b1 && cyc < 50) begin
         tick();
         cyc++;
      end
      check("latency", cyc, WIDTH);
   endtask

   task automatic check_result(input logic [3:0] exp_d, input logic exp_bout);
      logic [5:0] lhs;
      logic [5:0] rhs;
      check("d", {28'd0, bus.d}, {28'd0, exp_d});
      check("bout", {31'd0, bus.bout}, {31'd0, exp_bout});
      lhs = 6'(bus.d) + 6'(last_b) + 6'(last_bin);
      rhs = 6'(last_a) + (6'(bus.bout) << 4);
      check("invariant", {26'd0, lhs}, {26'd0, rhs});
   endtask

   task automatic handshake();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("out_valid_drop", {31'd0, bus.out_valid}, 32'd0);
      check("in_ready_after", {31'd0, bus.in_ready}, 32'd1);
   endtask

   // Full operation with the expected result routed through the scoreboard queue.
   task automatic run_op(input logic [3:0] a_v, input logic [3:0] b_v, input logic bin_v,
                         input int stall, input logic [3:0] exp_d, input logic exp_bout);
      logic [4:0] exp;
      exp_q.push_back({exp_bout, exp_d});
      start_op(a_v, b_v, bin_v);
      wait_valid();
      for (int i = 0; i < stall; i++) begin
         tick();
         check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
      end
      exp = exp_q.pop_front();
      check_result(exp[3:0], exp[4]);
      handshake();
   endtask

   initial begin
      logic [4:0] gold;

      rst_n         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.bin       = 1'b0;
      bus.out_ready = 1'b0;

      // 1: reset asserted mid-clock takes effect at once.
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_d", {28'd0, bus.d}, 32'd0);
      check("rst_bout", {31'd0, bus.bout}, 32'd0);
      check("rst_state", {30'd0, dbg_state}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

      // 2: basic subtraction.
      run_op(4'd9, 4'd3, 1'b0, 0, 4'd6, 1'b0);

      // 3: borrow cases.
      run_op(4'd3, 4'd9, 1'b0, 1, 4'hA, 1'b1);
      run_op(4'd0, 4'd0, 1'b1, 0, 4'hF, 1'b1);
      run_op(4'd0, 4'hF, 1'b1, 2, 4'h0, 1'b1);

      // 4: backpressure with an in_valid pulse that must be ignored.
      start_op(4'd12, 4'd5, 1'b0);
      wait_valid();
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            bus.a        = 4'd1;
            bus.b        = 4'd2;
            bus.bin      = 1'b1;
            bus.in_valid = 1'b1;
         end
         tick();
         bus.in_valid = 1'b0;
         check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
         check("bp_d", {28'd0, bus.d}, 32'd7);
         check("bp_bout", {31'd0, bus.bout}, 32'd0);
      end
      handshake();
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_idle_state", {30'd0, dbg_state}, 32'd0);
         check("bp_held_d", {28'd0, bus.d}, 32'd7);
         check("bp_no_valid", {31'd0, bus.out_valid}, 32'd0);
      end

      // 5: reset after two bit cycles aborts the operation.
      start_op(4'd10, 4'd1, 1'b0);
      tick();
      tick();
      #3;
      rst_n = 1'b0;
      #1;
      check("abort_state", {30'd0, dbg_state}, 32'd0);
      check("abort_valid", {31'd0, bus.out_valid}, 32'd0);
      check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("abort_no_valid", {31'd0, bus.out_valid}, 32'd0);
      end
      run_op(4'd5, 4'd2, 1'b0, 1, 4'd3, 1'b0);

      // 6: exhaustive sweep with random result stalls.
      for (int ai = 0; ai < 16; ai++) begin
         for (int bi = 0; bi < 16; bi++) begin
            for (int ci = 0; ci < 2; ci++) begin
               gold = 5'(ai) - 5'(bi) - 5'(ci);
               run_op(4'(ai), 4'(bi), 1'(ci), $urandom_range(0, 3), gold[3:0], gold[4]);
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
